// File: rtl/exdecompress_pipe_if.sv
// Word-stream handshake for the exbus decompressor: a valid strobe, a
// backward stall and a 35-bit command word.
interface exdecompress_pipe_if;
    logic        stb;
    logic        busy;
    logic [34:0] word;

    modport master (output stb, output word, input busy);
    modport slave  (input stb, input word, output busy);
endinterface

// File: rtl/exdecompress_pipe.sv
// Three-stage (decode, table, output) exbus word decompressor with a global
// stall and a write-value history table for repeated-write compression.
module exdecompress_pipe #(
    parameter int LGTBL        = 10,
    parameter bit OPT_LOWPOWER = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    exdecompress_pipe_if.slave   i_bus,
    exdecompress_pipe_if.master  o_bus
);

    typedef enum logic [1:0] {
        T_ADDR    = 2'b00,
        T_WRITE   = 2'b01,
        T_READ    = 2'b10,
        T_SPECIAL = 2'b11
    } word_type_e;

    logic [34:0]      w_in;
    word_type_e       w_type;
    logic [34:0]      w_word;
    logic             w_push;
    logic             w_lookup;
    logic [9:0]       w_k;
    logic             w_stall;
    logic [LGTBL-1:0] w_raddr;

    logic             r1_valid, r1_push, r1_lookup;
    logic [34:0]      r1_word;
    logic [9:0]       r1_k;
    logic             r2_valid, r2_lookup;
    logic [34:0]      r2_word;
    logic [31:0]      r2_rdata;
    logic             r_stb;
    logic [34:0]      r_word;
    logic [LGTBL-1:0] r_ptr;
    logic [31:0]      r_mem [0:(1<<LGTBL)-1];

    assign w_in    = i_bus.word;
    assign w_type  = word_type_e'(w_in[34:33]);
    assign w_stall = r_stb && o_bus.busy;
    // Table writes and lookups both happen on the table-stage edge in word
    // order, so every earlier push is already in memory when a lookup reads.
    assign w_raddr = r_ptr - LGTBL'(r1_k);

    assign i_bus.busy = w_stall;
    assign o_bus.stb  = r_stb;
    assign o_bus.word = r_word;

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        w_word   = '0;
        w_push   = 1'b0;
        w_lookup = 1'b0;
        w_k      = '0;
        case (w_type)
            T_ADDR: begin
                if (!w_in[32])
                    w_word = {3'b000, w_in[31:2], 1'b0, w_in[0]};
                else if (!w_in[31])
                    w_word = {3'b001, {29{w_in[30]}}, w_in[29], 1'b0, w_in[28]};
                else if (!w_in[30])
                    w_word = {2'b00, w_in[29], {24{w_in[28]}}, w_in[27:22], 1'b0, w_in[21]};
                else
                    w_word = {2'b00, w_in[29], {17{w_in[28]}}, w_in[27:15], 1'b0, w_in[14]};
            end
            T_WRITE: begin
                if (!w_in[32]) begin
                    w_word = {3'b010, w_in[31:0]};
                    w_push = 1'b1;
                end else if (!w_in[31]) begin
                    w_lookup = 1'b1;
                    w_k      = w_in[30] ? (10'(w_in[29:21]) + 10'd1)
                                        : (10'(w_in[29:28]) + 10'd1);
                end else if (!w_in[30]) begin
                    w_word = {3'b010, {24{w_in[28]}}, w_in[28:21]};
                end else begin
                    w_word = {3'b010, {17{w_in[28]}}, w_in[28:14]};
                    w_push = 1'b1;
                end
            end
            T_READ: begin
                if (!w_in[32])
                    w_word = {2'b10, 21'h0, 12'(w_in[31:28]) + 12'd1};
                else
                    w_word = {2'b10, 21'h0, 12'(w_in[31:21]) + 12'd17};
            end
            T_SPECIAL: w_word = {2'b11, w_in[32:28], 28'h0};
            default:   w_word = '0;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of code order.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r1_valid  <= 1'b0;
            r1_push   <= 1'b0;
            r1_lookup <= 1'b0;
            r1_word   <= '0;
            r1_k      <= '0;
            r2_valid  <= 1'b0;
            r2_lookup <= 1'b0;
            r2_word   <= '0;
            r2_rdata  <= '0;
            r_stb     <= 1'b0;
            r_word    <= '0;
            r_ptr     <= '0;
        end else if (!w_stall) begin
            r1_valid  <= i_bus.stb;
            r1_push   <= i_bus.stb && w_push;
            r1_lookup <= (OPT_LOWPOWER && !i_bus.stb) ? 1'b0 : w_lookup;
            r1_word   <= (OPT_LOWPOWER && !i_bus.stb) ? '0 : w_word;
            r1_k      <= (OPT_LOWPOWER && !i_bus.stb) ? '0 : w_k;

            r2_valid  <= r1_valid;
            r2_lookup <= (OPT_LOWPOWER && !r1_valid) ? 1'b0 : r1_lookup;
            r2_word   <= (OPT_LOWPOWER && !r1_valid) ? '0 : r1_word;
            r2_rdata  <= (OPT_LOWPOWER && !(r1_valid && r1_lookup)) ? '0 : r_mem[w_raddr];
            if (r1_valid && r1_push)
                r_ptr <= r_ptr + 1'b1;

            r_stb     <= r2_valid;
            if (OPT_LOWPOWER && !r2_valid)
                r_word <= '0;
            else
                r_word <= r2_lookup ? {3'b010, r2_rdata} : r2_word;
        end
    end

    // NOTE: the history table has no reset; clearing it would cost a cycle per
    // entry, and lookups only ever target entries pushed since reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !w_stall && r1_valid && r1_push)
            r_mem[r_ptr] <= r1_word[31:0];
    end

endmodule

// File: tb/tb_exdecompress_pipe.sv
// Scoreboard bench for exdecompress_pipe: directed cases, wrap and random
// traffic against a history-queue reference model.
module tb_exdecompress_pipe;

    typedef struct {
        logic [34:0] word;
        bit          dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec  = 0;
    int   n_fail = 0;
    int   busy_pct = 0;
    bit   last_acc;
    exp_t sb[$];
    logic [31:0] hist[$];

    exdecompress_pipe_if in_if ();
    exdecompress_pipe_if out_if ();

    exdecompress_pipe #(.LGTBL(10), .OPT_LOWPOWER(1'b0)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_bus   (in_if),
        .o_bus   (out_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: all pushes since reset kept in one unbounded queue.
    function automatic exp_t model(input logic [34:0] w);
        exp_t e;
        logic [31:0] v;
        bit push, look;
        int k, cnt;
        e.dc = 1'b0; e.word = '0; v = '0; push = 1'b0; look = 1'b0; k = 0;
        case (w[34:33])
            2'b00: begin
                if (!w[32])      e.word = {3'b000, w[31:2], 1'b0, w[0]};
                else if (!w[31]) e.word = {3'b001, 29'($signed(w[30:30])), w[29], 1'b0, w[28]};
                else if (!w[30]) e.word = {2'b00, w[29], 24'($signed(w[28:28])), w[27:22], 1'b0, w[21]};
                else             e.word = {2'b00, w[29], 17'($signed(w[28:28])), w[27:15], 1'b0, w[14]};
            end
            2'b01: begin
                if (!w[32]) begin v = w[31:0]; push = 1'b1; end
                else if (!w[31]) begin
                    look = 1'b1;
                    k = w[30] ? int'(w[29:21]) + 1 : int'(w[29:28]) + 1;
                end
                else if (!w[30]) v = 32'($signed(w[28:21]));
                else begin v = 32'($signed(w[28:14])); push = 1'b1; end
                if (look) begin
                    if (k > hist.size()) e.dc = 1'b1;
                    else v = hist[hist.size() - k];
                end
                e.word = {3'b010, v};
                if (push) hist.push_back(v);
            end
            2'b10: begin
                cnt = w[32] ? int'(w[31:21]) + 17 : int'(w[31:28]) + 1;
                e.word = {2'b10, 21'h0, 12'(cnt)};
            end
            default: e.word = {2'b11, w[32:28], 28'h0};
        endcase
        return e;
    endfunction

    task automatic cycle(input bit stb, input logic [34:0] w, input bit bsy);
        @(negedge clk);
        in_if.stb   = stb;
        in_if.word  = w;
        out_if.busy = bsy;
        #1;
        last_acc = stb && !rst && !in_if.busy;
        if (last_acc) sb.push_back(model(w));
    endtask

    task automatic send(input logic [34:0] w);
        for (int t = 0; t < 100; t++) begin
            cycle(1'b1, w, $urandom_range(99) < busy_pct);
            if (last_acc) return;
        end
        check("send_timeout", 1, 0);
    endtask

    task automatic drain();
        for (int t = 0; t < 60 && sb.size() > 0; t++) cycle(1'b0, '0, 1'b0);
        check("drain", sb.size(), 0);
    endtask

    function automatic logic [34:0] wr_full(input logic [31:0] v);
        return {2'b01, 1'b0, v};
    endfunction
    function automatic logic [34:0] lk_short(input int k);
        return {2'b01, 3'b100, 2'(k - 1), 28'h0};
    endfunction
    function automatic logic [34:0] lk_long(input int k);
        return {2'b01, 3'b101, 9'(k - 1), 21'h0};
    endfunction

    // Monitor: pops the scoreboard whenever a word leaves the DUT.
    initial begin
        bit prev_stall;
        logic [34:0] prev_word;
        exp_t e;
        prev_stall = 1'b0;
        prev_word  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev_stall = 1'b0;
                continue;
            end
            check("o_busy", in_if.busy, out_if.stb & out_if.busy);
            if (prev_stall) check("stall_hold", {out_if.stb, out_if.word}, {1'b1, prev_word});
            prev_stall = out_if.stb && out_if.busy;
            prev_word  = out_if.word;
            if (out_if.stb && !out_if.busy) begin
                if (sb.size() == 0) begin
                    n_vec++; n_fail++;
                    $display("FAIL spurious_out: got %h, expected no word", out_if.word);
                end else begin
                    e = sb.pop_front();
                    if (!e.dc) check("o_word", out_if.word, e.word);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] r;
        in_if.stb = 1'b1; in_if.word = 35'h1_2345_6789; out_if.busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 35'(i * 35'h0_0F0F_0F0F), 1'b0);
            if (i > 0) check("rst_ostb", out_if.stb, 0);
        end
        rst = 1'b0; in_if.stb = 1'b0;
        cycle(1'b0, '0, 1'b0);
        check("post_rst_word", {out_if.stb, out_if.word}, 0);

        // Latency: word accepted on clock 1 appears after clock 3.
        cycle(1'b1, 35'h0_1234_5678, 1'b0);
        cycle(1'b0, '0, 1'b0); check("lat1", out_if.stb, 0);
        cycle(1'b0, '0, 1'b0); check("lat2", out_if.stb, 0);
        cycle(1'b0, '0, 1'b0); check("lat3", out_if.stb, 1);
        drain();

        // Back-to-back pushes with immediate lookups.
        send(wr_full(32'hDEADBEEF));
        send(wr_full(32'h01234567));
        send(lk_short(1));
        send(lk_short(2));
        drain();

        // Global stall with three words in flight.
        send(wr_full(32'hAAAA0001));
        send(wr_full(32'hAAAA0002));
        send(wr_full(32'hAAAA0003));
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, '0, 1'b1);
            check("o_busy_stall", in_if.busy, 1);
        end
        send(lk_short(1));
        drain();

        // Read counts and short write not pushed.
        send({2'b10, 1'b1, 11'h7FF, 21'h0});
        send({2'b10, 1'b0, 4'h0, 28'h0});
        send(wr_full(32'h13579BDF));
        send({2'b01, 3'b110, 1'b0, 8'h80, 21'h0});
        send(lk_short(1));
        send(wr_full(32'h2468ACE0));
        drain();

        // Table wrap: more pushes than entries, then long lookups.
        busy_pct = 10;
        for (int i = 0; i < 1027; i++) send(wr_full(32'hC0000000 ^ (32'(i) * 32'h9E3779B9)));
        send(lk_long(512));
        send(lk_long(1));
        send(lk_short(4));
        drain();

        // Random traffic with a reset in the middle of the stream.
        busy_pct = 30;
        for (int n = 0; n < 2500; n++) begin
            if (n == 1200) begin
                rst = 1'b1; in_if.stb = 1'b0;
                sb.delete(); hist.delete();
                cycle(1'b0, '0, 1'b0);
                cycle(1'b0, '0, 1'b0);
                check("mid_rst_ostb", out_if.stb, 0);
                rst = 1'b0;
            end
            r = {$urandom(), $urandom()};
            cycle($urandom_range(99) < 80, r[34:0], $urandom_range(99) < busy_pct);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
